// File: rtl/lif_timestep_scheduler.sv
// lif_timestep_scheduler
// Time-multiplexes one 2-input leaky integrate-and-fire update across
// N_NEURONS neurons. Each start pulse walks neurons 0..N_NEURONS-1: fetch
// operands over rd_req/rd_ack, leak + integrate + saturate, fire or hold,
// then pulse done. Membrane and refractory state live in local registers.
// Optional build macro: LIF_SPIKE_COUNT_EN adds a per-timestep spike counter
// on output spike_cnt.
module lif_timestep_scheduler #(
   parameter int N_NEURONS  = 4,
   parameter int WIDTH      = 8,
   parameter int V_TH       = 10,
   parameter int V_RESET    = 0,
   parameter int LEAK_SHIFT = 4,
   parameter int REFRAC     = 2,
   localparam int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             rd_req,
   output logic [IDX_W-1:0] rd_idx,
   input  logic             rd_ack,
   input  logic [WIDTH-1:0] weight0,
   input  logic [WIDTH-1:0] weight1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic [WIDTH-1:0] v_out,
   output logic             v_valid,
   output logic             spike_valid,
   output logic [IDX_W-1:0] spike_idx,
   output logic             done
`ifdef LIF_SPIKE_COUNT_EN
   ,
   output logic [$clog2(N_NEURONS+1)-1:0] spike_cnt
`endif
);

   // Sum is wide enough for two full products plus the leaked potential.
   localparam int EXT = 2*WIDTH + 2;
   localparam int RW  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam logic signed [WIDTH-1:0] TH        = WIDTH'(V_TH);
   localparam logic        [WIDTH-1:0] VR        = WIDTH'(V_RESET);
   localparam logic        [RW-1:0]    REFRAC_LD = RW'(REFRAC);
   localparam logic        [IDX_W-1:0] LAST      = IDX_W'(N_NEURONS - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_UPDATE, S_DONE} state_t;

   state_t            r_state, w_next;
   logic [IDX_W-1:0]  r_idx;
   logic [WIDTH-1:0]  r_v      [N_NEURONS];
   logic [RW-1:0]     r_refrac [N_NEURONS];
   logic [WIDTH-1:0]  r_w0, r_w1, r_d0, r_d1;

   logic signed [WIDTH-1:0] w_v_cur, w_leak, w_sat, w_v_new;
   logic signed [EXT-1:0]   w_sum;
   logic                    w_ovf, w_in_refrac, w_fire;
   logic [RW-1:0]           w_refrac_new;

   function automatic logic signed [EXT-1:0] sext(input logic [WIDTH-1:0] x);
      return {{(EXT-WIDTH){x[WIDTH-1]}}, x};
   endfunction

   // State register.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic: start only counts in IDLE, ack only counts in FETCH.
   // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start)  w_next = S_FETCH;
         S_FETCH:  if (rd_ack) w_next = S_UPDATE;
         S_UPDATE: w_next = (r_idx == LAST) ? S_DONE : S_FETCH;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Shared LIF datapath for the neuron currently addressed by r_idx.
   always_comb begin
      w_v_cur = r_v[r_idx];
      w_leak  = w_v_cur >>> LEAK_SHIFT;
      w_sum   = sext(w_v_cur) - sext(w_leak)
              + sext(r_w0) * sext(r_d0) + sext(r_w1) * sext(r_d1);
      // Out of range when the bits above the result sign disagree with it.
      w_ovf   = (w_sum[EXT-1:WIDTH-1] != {(EXT-WIDTH+1){w_sum[EXT-1]}});
      if (w_ovf) w_sat = w_sum[EXT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
      else       w_sat = w_sum[WIDTH-1:0];
      w_in_refrac  = (r_refrac[r_idx] != '0);
      w_fire       = !w_in_refrac && (w_sat >= TH);
      w_v_new      = (w_in_refrac || w_fire) ? VR : w_sat;
      w_refrac_new = w_in_refrac ? r_refrac[r_idx] - RW'(1)
                                 : (w_fire ? REFRAC_LD : '0);
   end

   // Output decode: everything is a function of state, so reset forces all to 0.
   always_comb begin
      busy        = (r_state != S_IDLE);
      rd_req      = (r_state == S_FETCH);
      rd_idx      = (r_state == S_FETCH)  ? r_idx   : '0;
      v_valid     = (r_state == S_UPDATE);
      spike_valid = (r_state == S_UPDATE) && w_fire;
      spike_idx   = (r_state == S_UPDATE) ? r_idx   : '0;
      v_out       = (r_state == S_UPDATE) ? w_v_new : '0;
      done        = (r_state == S_DONE);
   end

   // Neuron pointer: cleared on start acceptance, advanced after each update.
   always_ff @(posedge clk) begin
      if (!reset)                                   r_idx <= '0;
      else if (r_state == S_IDLE && start)          r_idx <= '0;
      else if (r_state == S_UPDATE && r_idx != LAST) r_idx <= r_idx + IDX_W'(1);
   end

   // Per-neuron membrane and refractory state, written once per UPDATE.
   // NOTE: this array is architectural state that must read V_RESET after
   // reset, so it is reset element by element rather than left uninitialised.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            r_v[i]      <= VR;
            r_refrac[i] <= '0;
         end
      end else if (r_state == S_UPDATE) begin
         r_v[r_idx]      <= w_v_new;
         r_refrac[r_idx] <= w_refrac_new;
      end
   end

   // Operand capture on the handshake.
   // NOTE: no reset here; these are only consumed in the UPDATE cycle that
   // always follows a capture, so their power-up value is never observed.
   always_ff @(posedge clk) begin
      if (r_state == S_FETCH && rd_ack) begin
         r_w0 <= weight0;
         r_d0 <= data0;
         r_w1 <= weight1;
         r_d1 <= data1;
      end
   end

`ifdef LIF_SPIKE_COUNT_EN
   localparam int CNT_W = $clog2(N_NEURONS + 1);
   logic [CNT_W-1:0] r_spike_cnt;

   // Spikes in the current timestep; holds after done until the next start.
   always_ff @(posedge clk) begin
      if (!reset)                              r_spike_cnt <= '0;
      else if (r_state == S_IDLE && start)     r_spike_cnt <= '0;
      else if (r_state == S_UPDATE && w_fire)  r_spike_cnt <= r_spike_cnt + CNT_W'(1);
   end

   assign spike_cnt = r_spike_cnt;
`endif

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// Directed bench for lif_timestep_scheduler (default parameters).
module tb_lif_timestep_scheduler;
   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset, start, rd_ack;
   logic       busy, rd_req, v_valid, spike_valid, done;
   logic [1:0] rd_idx, spike_idx;
   logic [7:0] weight0, weight1, data0, data1, v_out;
`ifdef LIF_SPIKE_COUNT_EN
   logic [2:0] spike_cnt;
`endif

   logic [7:0] op_w0 [N];
   logic [7:0] op_d0 [N];
   logic [7:0] op_w1 [N];
   logic [7:0] op_d1 [N];
   int         exp_v [N];
   bit         exp_s [N];
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   lif_timestep_scheduler dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy),
      .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack),
      .weight0(weight0), .weight1(weight1), .data0(data0), .data1(data1),
      .v_out(v_out), .v_valid(v_valid), .spike_valid(spike_valid),
      .spike_idx(spike_idx), .done(done)
`ifdef LIF_SPIKE_COUNT_EN
      , .spike_cnt(spike_cnt)
`endif
   );

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_ops(input int i, input logic [7:0] w0, input logic [7:0] d0,
                          input logic [7:0] w1, input logic [7:0] d1);
      op_w0[i] = w0; op_d0[i] = d0; op_w1[i] = w1; op_d1[i] = d1;
   endtask

   task automatic clear_ops();
      for (int i = 0; i < N; i++) set_ops(i, 8'd0, 8'd0, 8'd0, 8'd0);
   endtask

   task automatic set_exp(input int a, input int b, input int c, input int d,
                          input bit [3:0] s);
      exp_v[0] = a; exp_v[1] = b; exp_v[2] = c; exp_v[3] = d;
      for (int i = 0; i < N; i++) exp_s[i] = s[i];
   endtask

   // Present the operands of whichever neuron is being requested.
   task automatic drive_ops();
      weight0 = op_w0[rd_idx]; data0 = op_d0[rd_idx];
      weight1 = op_w1[rd_idx]; data1 = op_d1[rd_idx];
   endtask

   task automatic check_outputs_zero(input string pfx);
      check({pfx, "_busy"},        32'(busy),        0);
      check({pfx, "_rd_req"},      32'(rd_req),      0);
      check({pfx, "_rd_idx"},      32'(rd_idx),      0);
      check({pfx, "_v_valid"},     32'(v_valid),     0);
      check({pfx, "_v_out"},       32'(v_out),       0);
      check({pfx, "_spike_valid"}, 32'(spike_valid), 0);
      check({pfx, "_spike_idx"},   32'(spike_idx),   0);
      check({pfx, "_done"},        32'(done),        0);
`ifdef LIF_SPIKE_COUNT_EN
      check({pfx, "_spike_cnt"},   32'(spike_cnt),   0);
`endif
   endtask

   // One full timestep against exp_v/exp_s; optional ack stall and start poke.
   task automatic run_ts(input string name, input int stall_idx,
                         input int stall_n, input bit poke);
      int cyc, n, stall_left, exp_cnt;
      bit got_done, stall_seen;
      cyc = 0; n = 0; got_done = 0; stall_seen = 0; stall_left = stall_n;
      exp_cnt = 0;
      for (int i = 0; i < N; i++) exp_cnt += int'(exp_s[i]);
      @(negedge clk);
      start = 1'b1; rd_ack = 1'b1;
      @(posedge clk);
      while (!got_done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         start = poke && (cyc == 3);
         drive_ops();
`ifdef LIF_SPIKE_COUNT_EN
         if (cyc == 1) check({name, "_spike_cnt_clr"}, 32'(spike_cnt), 0);
`endif
         if (spike_valid && !v_valid) check({name, "_spike_without_v"}, 1, 0);
         if (v_valid) begin
            if (n < N) begin
               check($sformatf("%s_n%0d_idx", name, n),   32'(spike_idx), n);
               check($sformatf("%s_n%0d_v", name, n),     32'($signed(v_out)), exp_v[n]);
               check($sformatf("%s_n%0d_spike", name, n), 32'(spike_valid), 32'(exp_s[n]));
            end else begin
               check({name, "_extra_update"}, n, N - 1);
            end
            n++;
         end
         if (done) begin
            got_done = 1'b1;
            check({name, "_done_cycle"}, cyc, 2*N + 1 + stall_n);
            check({name, "_updates"},    n,   N);
`ifdef LIF_SPIKE_COUNT_EN
            check({name, "_spike_cnt"},  32'(spike_cnt), exp_cnt);
`endif
         end
         if (stall_n > 0 && !stall_seen && rd_req && int'(rd_idx) == stall_idx)
            stall_seen = 1'b1;
         if (stall_seen && stall_left >= 0) begin
            check({name, "_stall_rd_req"}, 32'(rd_req), 1);
            check({name, "_stall_rd_idx"}, 32'(rd_idx), stall_idx);
         end
         if (stall_seen && stall_left > 0) begin
            rd_ack = 1'b0;
            stall_left--;
         end else begin
            rd_ack = 1'b1;
            if (stall_seen) stall_left = -1;
         end
      end
      if (!got_done) check({name, "_done_timeout"}, 0, 1);
      start = 1'b0; rd_ack = 1'b1;
      @(negedge clk);
      check({name, "_idle_busy"}, 32'(busy), 0);
      check({name, "_idle_done"}, 32'(done), 0);
   endtask

   initial begin
      bit found;
      int dn;
      reset = 1'b0; start = 1'b0; rd_ack = 1'b0;
      weight0 = '0; weight1 = '0; data0 = '0; data1 = '0;
      clear_ops();
      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b1;

      // Basic integrate, spike, refractory and recovery on neuron 0.
      set_ops(0, 8'd3, 8'd2, 8'd2, 8'd1);
      set_exp(8, 0, 0, 0, 4'b0000); run_ts("ts1", 0, 0, 1'b0);
      set_exp(0, 0, 0, 0, 4'b0001); run_ts("ts2", 0, 0, 1'b0);
      set_exp(0, 0, 0, 0, 4'b0000); run_ts("ts3", 0, 0, 1'b0);
      set_exp(0, 0, 0, 0, 4'b0000); run_ts("ts4", 0, 0, 1'b0);
      set_exp(8, 0, 0, 0, 4'b0000); run_ts("ts5", 0, 0, 1'b0);

      // Saturation both ways; the positive one fires and reports V_RESET.
      clear_ops();
      set_ops(1, 8'd127, 8'd127, 8'd0, 8'd0);
      set_ops(2, 8'h80,  8'd127, 8'd0, 8'd0);
      set_exp(8, 0, -128, 0, 4'b0010); run_ts("ts6", 0, 0, 1'b0);

      // Negative leak toward zero, 5-cycle ack stall on neuron 2, start poke while busy.
      clear_ops();
      set_exp(8, 0, -120, 0, 4'b0000); run_ts("ts7", 2, 5, 1'b1);
      set_exp(8, 0, -112, 0, 4'b0000); run_ts("ts8", 0, 0, 1'b0);

      // Reset during the UPDATE of neuron 1.
      found = 1'b0;
      @(negedge clk);
      start = 1'b1; rd_ack = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         start = 1'b0;
         drive_ops();
         if (v_valid && spike_idx == 2'd1) found = 1'b1;
      end
      check("midreset_reached_n1", 32'(found), 1);
      reset = 1'b0;
      @(negedge clk);
      check_outputs_zero("midreset");
      reset = 1'b1;
      dn = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done || busy) dn++;
      end
      check("midreset_no_done_busy", dn, 0);
      set_exp(0, 0, 0, 0, 4'b0000); run_ts("ts9", 0, 0, 1'b0);

      // Threshold boundary: exactly V_TH fires, one below does not.
      set_ops(0, 8'd5, 8'd2, 8'd0, 8'd0);
      set_ops(1, 8'd4, 8'd4, 8'd0, 8'd0);
      set_ops(2, 8'd3, 8'd3, 8'd0, 8'd0);
      set_exp(0, 0, 9, 0, 4'b0011); run_ts("ts10", 0, 0, 1'b0);
      clear_ops();
      set_exp(0, 0, 9, 0, 4'b0000); run_ts("ts11", 0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
